// File: rtl/matrix_pkg.sv
// Shared types and constants for the 8x8 LED matrix scan controller.
//   ROWS / COLS  : matrix geometry
//   scan_state_t : row timer phases (BLANK, ON)
//   row_t        : one row of pixel bits / one anode drive word
//   onehot_row() : row index -> one-hot anode pattern
package matrix_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  typedef logic [COLS-1:0] row_t;

  function automatic row_t onehot_row(input logic [2:0] idx);
    row_t r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/matrix_row_timer.sv
// Row timer for the matrix scan: alternates a BLANK interval and an ON
// interval for each row, walking row 0..7, and subdivides ON into 16 PWM
// slots.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   row_idx_o      : row currently being scanned
//   on_phase_o     : 1 while in the ON interval
//   slot_o         : PWM slot 0..15 within ON
//   frame_start_o  : 1 in the first BLANK cycle of row 0
//   frame_end_o    : 1 in the last ON cycle of row 7
module matrix_row_timer
  import matrix_pkg::*;
#(
  parameter int unsigned ROW_CYCLES   = 3360,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [2:0] row_idx_o,
  output logic       on_phase_o,
  output logic [3:0] slot_o,
  output logic       frame_start_o,
  output logic       frame_end_o
);

  localparam int unsigned SLOT      = ROW_CYCLES / 16;
  localparam int unsigned DWELL_MAX = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W     = $clog2(DWELL_MAX);
  localparam int unsigned SUB_W     = (SLOT > 1) ? $clog2(SLOT) : 1;

  localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SLOT - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(ROWS - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [3:0]       slot_q, slot_d;
  logic [2:0]       idx_q, idx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      sub_q   <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ON;
          cnt_d   = '0;
          sub_d   = '0;
          slot_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ON: begin
        if (cnt_q == ROW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          sub_d   = '0;
          slot_d  = '0;
          idx_d   = idx_q + 1'b1;   // wraps 7 -> 0
        end else begin
          cnt_d = cnt_q + 1'b1;
          // sub counts cycles inside a slot; slot advances every SLOT cycles
          if (sub_q == SUB_LAST) begin
            sub_d  = '0;
            slot_d = slot_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign row_idx_o     = idx_q;
  assign on_phase_o    = (state_q == ON);
  assign slot_o        = slot_q;
  assign frame_start_o = (state_q == BLANK) && (cnt_q == '0) && (idx_q == '0);
  assign frame_end_o   = (state_q == ON) && (cnt_q == ROW_LAST) && (idx_q == IDX_LAST);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Scan scheduler for the 8x8 LED matrix: double-buffered frame store,
// frame-boundary swap, per-row blank + PWM-dimmed on interval.
//   clk, rst     : clock, synchronous active-high reset
//   wr_en/wr_row/wr_data : write one row into the back buffer
//   swap_req     : request front/back exchange at next frame boundary
//   swap_ack     : one-cycle pulse when the swap takes effect
//   brightness   : duty 0..15, captured at frame start
//   frame_start  : one-cycle pulse as row 0 enters blank
//   row          : one-hot anode drive (0 during blank)
//   col          : column drive, 1 = lit
// All outputs are registered from the row timer state, so they trail the
// timer by one cycle; frame_start therefore appears in the cycle after the
// timer sits in its frame-start state.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int unsigned ROW_CYCLES   = 3360,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  input  logic [3:0] brightness,
  output logic       frame_start,
  output logic [7:0] row,
  output logic [7:0] col
);

  logic [2:0] tmr_row_idx;
  logic       tmr_on_phase;
  logic [3:0] tmr_slot;
  logic       tmr_frame_start;
  logic       tmr_frame_end;

  matrix_row_timer #(
    .ROW_CYCLES  (ROW_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk_i        (clk),
    .rst_i        (rst),
    .row_idx_o    (tmr_row_idx),
    .on_phase_o   (tmr_on_phase),
    .slot_o       (tmr_slot),
    .frame_start_o(tmr_frame_start),
    .frame_end_o  (tmr_frame_end)
  );

  row_t [1:0][ROWS-1:0] bank_q, bank_d;
  logic                 front_sel_q, front_sel_d;
  logic                 pending_q, pending_d;
  logic [3:0]           bright_q, bright_d;
  row_t                 row_q, row_d;
  row_t                 col_q, col_d;
  logic                 swap_ack_q, swap_ack_d;
  logic                 frame_start_q, frame_start_d;
  logic                 swap_now;

  always_comb begin
    bank_d        = bank_q;
    // A write in the swap cycle still targets the current back bank,
    // which is exactly the bank becoming front.
    if (wr_en) begin
      bank_d[!front_sel_q][wr_row] = wr_data;
    end

    swap_now      = tmr_frame_end && (pending_q || swap_req);
    front_sel_d   = front_sel_q ^ swap_now;
    pending_d     = swap_now ? 1'b0 : (pending_q | swap_req);
    bright_d      = tmr_frame_start ? brightness : bright_q;

    row_d         = tmr_on_phase ? onehot_row(tmr_row_idx) : '0;
    col_d         = (tmr_on_phase && (tmr_slot < bright_q)) ?
                    bank_q[front_sel_q][tmr_row_idx] : '0;
    swap_ack_d    = swap_now;
    frame_start_d = tmr_frame_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q        <= '0;
      front_sel_q   <= 1'b0;
      pending_q     <= 1'b0;
      bright_q      <= '0;
      row_q         <= '0;
      col_q         <= '0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      bank_q        <= bank_d;
      front_sel_q   <= front_sel_d;
      pending_q     <= pending_d;
      bright_q      <= bright_d;
      row_q         <= row_d;
      col_q         <= col_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row         = row_q;
  assign col         = col_q;
  assign swap_ack    = swap_ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/matrix_scan_ctrl.md
# matrix_scan_ctrl

Scan scheduler for the 8x8 LED matrix. It owns two 8x8 frame buffers and sequences the row-multiplexed scan. Each row gets an anti-ghosting blank interval, then a PWM-dimmed on interval. Display content is swapped only at frame boundaries, so producers (clock face, menu, animations) never cause tearing. It sits between the content logic and the anode/cathode pins; the board-level inversion of `col` onto the cathodes stays outside this block.

## Interface
- `ROW_CYCLES`, 3360, clk cycles of the on interval per row; must be a nonzero multiple of 16.
- `BLANK_CYCLES`, 16, clk cycles of the blank interval before each row; must be ≥1.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous and active-high.
- `wr_en` in 1: write `wr_data` into row `wr_row` of the back buffer.
- `wr_row` in 3: row index for the write.
- `wr_data` in 8: pixel bits for the row; bit i = column i, 1 = lit.
- `swap_req` in 1: level or pulse; requests a front/back exchange at the next frame boundary.
- `swap_ack` out 1: one-cycle pulse in the cycle the swap takes effect.
- `brightness` in 4: duty level 0..15; sampled at frame start.
- `frame_start` out 1: one-cycle pulse when row 0 enters its blank interval.
- `row` out 8: one-hot anode drive, active high; all-zero during blank.
- `col` out 8: column drive, active high (1 = pixel lit).

## Operation
- Storage is two banks of 8×8 bits. A `front_sel` bit picks which bank is displayed; the other bank is the back buffer. Writes always target the back buffer.
- Scan FSM states and transitions:
  - BLANK: `row`=0, `col`=0, for BLANK_CYCLES cycles, then go to ON.
  - ON: `row`=one-hot(`row_idx`), for ROW_CYCLES cycles, then go to BLANK with `row_idx` incremented mod 8.
- PWM within ON:
  - SLOT = ROW_CYCLES/16. The ON interval is divided into 16 slots, s = 0..15.
  - `col` = front[`row_idx`] during slots s < `bright_q`; otherwise `col` = 0.
  - `bright_q`=0 keeps the matrix dark. `bright_q`=15 gives 15/16 duty.
  - `row` stays asserted for the full ON interval regardless of duty.
- Frame boundary: the last cycle of ON with `row_idx`=7.
- Swap:
  - A `swap_req` sample sets `pending`.
  - At a frame boundary with `pending` set, or with `swap_req` high in that same cycle: toggle `front_sel`, clear `pending`, pulse `swap_ack` in that cycle.
  - Further `swap_req` while `pending` is set has no added effect; at most one swap per frame.
  - The back buffer is not cleared or copied on swap; it holds the previous front content.
- Write coincident with a swap: the write lands in the bank that becomes front in that cycle. That bank was the back buffer during that cycle.
- `bright_q` is loaded from `brightness` in the cycle `frame_start` pulses. Changes to `brightness` mid-frame have no effect until the next frame.

## Timing
- Reset values:
  - `row`=0, `col`=0, `swap_ack`=0, `frame_start`=0.
  - Both banks cleared, `front_sel`=0, `pending`=0, `bright_q`=0.
  - `row_idx`=0, FSM state BLANK with its counter at 0.
- First `frame_start` pulse: the first cycle after `rst` deasserts.
- Reset mid-frame returns to the reset state in the next cycle. Any pending swap and all buffer contents are lost.
- Frame period: 8×(BLANK_CYCLES+ROW_CYCLES) cycles. With defaults this is 27008 cycles, about 1000 Hz at 27 MHz.
- Outputs `row`, `col`, `swap_ack`, `frame_start` are registered; no combinational path from any input to any output.
- `col` reflects the front bank with one cycle of registering. A written row becomes visible only after a swap, starting at the first ON of that row in the following frame.
- Counters are sized with `$clog2`. `row_idx` wraps 7→0. Slot and dwell counters reset to 0 at every state entry.

## Structure
- Package `matrix_pkg`:
  - `ROWS`=8 and `COLS`=8.
  - `scan_state_t` enum {BLANK, ON}.
  - `row_t` typedef, `logic [7:0]`.
- Sub-module `matrix_row_timer`:
  - Contains the BLANK/ON FSM and the dwell/slot counters.
  - Outputs `row_idx`, `on_phase`, `slot`, `frame_start`, `frame_end`.
  - The top holds the buffers, swap logic and PWM gating.

## Test plan
- Reset, then `brightness`=15 and no writes: `row` walks 0x01…0x80 with BLANK_CYCLES gaps; `col` stays 0; `frame_start` repeats every 27008 cycles.
- Write row 3 = 0xA5, pulse `swap_req`: `swap_ack` fires exactly at the end of row 7's ON. In the next frame, `col`=0xA5 only while `row`=0x08, for the first 15×210 cycles of ON.
- `brightness`=4: `col` is active for exactly 840 cycles per lit row. `brightness`=0: `col` is never nonzero. A change of `brightness` mid-frame takes effect at the next `frame_start`.
- `swap_req` held high for 3 frames: `swap_ack` pulses once per frame boundary and `front_sel` alternates. Two pulses within one frame produce one swap.
- `wr_en` and a swap in the same cycle (row 0 = 0xFF): 0xFF is displayed in the very next frame.
- `rst` asserted mid-ON of row 5 with a swap pending: next cycle `row`=0 and `col`=0. No `swap_ack` follows, and a fresh `frame_start` arrives 1 cycle after release.
